// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: digit record, segment
// constants and the per-slot scan phase.
package seg7_pkg;
    localparam int          DIGIT_W     = 4;
    localparam logic [6:0]  SEG_BLANK   = 7'b0;
    localparam logic [3:0]  BRIGHT_FULL = 4'hF;

    typedef struct packed {
        logic               dp;
        logic [DIGIT_W-1:0] value;
    } digit_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_t;
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Writer-side bus of the scan controller: shadow register writes plus brightness.
interface seg7_scan_ctrl_if;
    import seg7_pkg::*;

    logic               wr_en;
    logic [2:0]         wr_idx;
    logic [DIGIT_W-1:0] wr_data;
    logic               wr_dp;
    logic [3:0]         brightness;

    modport master (output wr_en, wr_idx, wr_data, wr_dp, brightness);
    modport slave  (input  wr_en, wr_idx, wr_data, wr_dp, brightness);
endinterface

// File: rtl/seg7_scan_ctrl_dec.sv
// BCD to 7-segment decoder, seg[0]=a .. seg[6]=g, active high.
// Non-BCD codes decode to all segments off.
module seg7_scan_ctrl_dec
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] value,
    output logic [6:0]         seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode 7-segment display with
// anti-ghost blanking, PWM brightness and frame-synchronous shadow commit.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int          NUM_DIGITS   = 4,
    parameter logic [23:0] SCAN_DIV     = 24'd10000,
    parameter logic [15:0] BLANK_CYCLES = 16'd200
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_scan_ctrl_if.slave       bus,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_done
);
    localparam scan_state_t RST_STATE = (BLANK_CYCLES != 16'd0) ? ST_BLANK : ST_ON;

    logic [23:0] slot_cnt, slot_nxt;
    logic [2:0]  digit_idx;
    logic [3:0]  pwm_cnt;
    logic        slot_end, last_digit, commit;

    scan_state_t state_q, state_d;

    digit_t [NUM_DIGITS-1:0] shadow_q, shadow_d, active_q;
    digit_t                  cur;
    logic [6:0]              cur_seg;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   digit_en_d;

    assign slot_end   = (slot_cnt == SCAN_DIV - 24'd1);
    assign last_digit = (digit_idx == 3'(NUM_DIGITS - 1));
    assign commit     = slot_end && last_digit;
    assign slot_nxt   = slot_end ? 24'd0 : slot_cnt + 24'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt  <= 24'd0;
            digit_idx <= 3'd0;
        end else begin
            slot_cnt <= slot_nxt;
            if (slot_end)
                digit_idx <= last_digit ? 3'd0 : digit_idx + 3'd1;
        end
    end

    // Phase register tracks slot_cnt one-to-one, so it is derived from slot_nxt.
    always_ff @(posedge clk) begin
        if (reset) state_q <= RST_STATE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (slot_nxt < {8'd0, BLANK_CYCLES}) ? ST_BLANK : ST_ON;
    end

    always_comb begin
        lit = (state_q == ST_ON) &&
              ((bus.brightness == BRIGHT_FULL) || (pwm_cnt < bus.brightness));
        for (int i = 0; i < NUM_DIGITS; i++)
            digit_en_d[i] = lit && (digit_idx == 3'(i));
    end

    always_ff @(posedge clk) begin
        if (reset || state_q != ST_ON) pwm_cnt <= 4'd0;
        else                           pwm_cnt <= pwm_cnt + 4'd1;
    end

    // Out-of-range indices simply match no entry and are dropped.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bus.wr_en && bus.wr_idx == 3'(i))
                shadow_d[i] = '{dp: bus.wr_dp, value: bus.wr_data};
    end

    // Commit takes shadow_d so a write in the commit cycle lands this frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            if (commit) active_q <= shadow_d;
        end
    end

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (digit_idx == 3'(i)) cur = active_q[i];
    end

    seg7_scan_ctrl_dec u_dec (
        .value (cur.value),
        .seg   (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_out    <= SEG_BLANK;
            dp_out     <= 1'b0;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= lit ? cur_seg : SEG_BLANK;
            dp_out     <= lit && cur.dp;
            digit_en   <= digit_en_d;
            frame_done <= commit;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (SCAN_DIV 8 and 34) share one writer
// bus; an arithmetic model of the scan timeline is compared every cycle.
module tb_seg7_scan_ctrl;
    localparam int N  = 4;
    localparam int BL = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if bus();

    logic [6:0]   seg0, seg1;
    logic         dp0, dp1, fd0, fd1;
    logic [N-1:0] en0, en1;

    seg7_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(24'd8), .BLANK_CYCLES(16'd2)) u0 (
        .clk(clk), .reset(reset), .bus(bus),
        .seg_out(seg0), .dp_out(dp0), .digit_en(en0), .frame_done(fd0));

    seg7_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(24'd34), .BLANK_CYCLES(16'd2)) u1 (
        .clk(clk), .reset(reset), .bus(bus),
        .seg_out(seg1), .dp_out(dp1), .digit_en(en1), .frame_done(fd1));

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [6:0] segtab(input logic [3:0] v);
        logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        return tab[v];
    endfunction

    // Timeline model: t = cycles since reset release.
    function automatic int dig_at(input int t, input int sd);
        return (t / sd) % N;
    endfunction

    function automatic logic lit_at(input int t, input int sd, input logic [3:0] b);
        int pos = t % sd;
        if (pos < BL) return 1'b0;
        return (b == 4'hF) || (((pos - BL) % 16) < int'(b));
    endfunction

    function automatic logic fend_at(input int t, input int sd);
        return ((t % sd) == sd - 1) && (dig_at(t, sd) == N - 1);
    endfunction

    int         sd [2] = '{8, 34};
    int         mt [2];
    logic [4:0] sh [2][N];
    logic [4:0] act[2][N];
    logic [6:0] e_seg[2];
    logic       e_dp [2];
    logic       e_fd [2];
    logic [3:0] e_en [2];
    logic       armed = 1'b0;

    function automatic logic [4:0] wval(input logic [4:0] old, input int j);
        if (bus.wr_en && int'(bus.wr_idx) == j) return {bus.wr_dp, bus.wr_data};
        return old;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mt[k]    <= 0;
                e_seg[k] <= '0;
                e_dp[k]  <= 1'b0;
                e_fd[k]  <= 1'b0;
                e_en[k]  <= '0;
                for (int j = 0; j < N; j++) begin
                    sh[k][j]  <= '0;
                    act[k][j] <= '0;
                end
                armed <= 1'b1;
            end else begin
                e_en[k]  <= lit_at(mt[k], sd[k], bus.brightness) ? 4'(1 << dig_at(mt[k], sd[k])) : 4'd0;
                e_seg[k] <= lit_at(mt[k], sd[k], bus.brightness) ? segtab(act[k][dig_at(mt[k], sd[k])][3:0]) : 7'd0;
                e_dp[k]  <= lit_at(mt[k], sd[k], bus.brightness) && act[k][dig_at(mt[k], sd[k])][4];
                e_fd[k]  <= fend_at(mt[k], sd[k]);
                for (int j = 0; j < N; j++) begin
                    sh[k][j] <= wval(sh[k][j], j);
                    if (fend_at(mt[k], sd[k])) act[k][j] <= wval(sh[k][j], j);
                end
                mt[k] <= mt[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m0_en",  32'(en0),  32'(e_en[0]));
            chk("m0_seg", 32'(seg0), 32'(e_seg[0]));
            chk("m0_dp",  32'(dp0),  32'(e_dp[0]));
            chk("m0_fd",  32'(fd0),  32'(e_fd[0]));
            chk("m1_en",  32'(en1),  32'(e_en[1]));
            chk("m1_seg", 32'(seg1), 32'(e_seg[1]));
            chk("m1_dp",  32'(dp1),  32'(e_dp[1]));
            chk("m1_fd",  32'(fd1),  32'(e_fd[1]));
        end
    end

    task automatic wait_fd(input logic zero_chk);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (zero_chk && en0 != 0) chk("old_frame_seg", 32'(seg0), 32'h3F);
        end while (fd0 !== 1'b1 && n < 100);
        chk("frame_done_seen", 32'(fd0), 32'd1);
    endtask

    task automatic window(input int len, input logic [3:0][6:0] eseg, input logic [3:0] edp,
                          output logic [3:0][7:0] c0, output int c1);
        c0 = '0;
        c1 = 0;
        repeat (len) begin
            @(negedge clk);
            for (int d = 0; d < N; d++)
                if (en0 == 4'(1 << d)) begin
                    c0[d] = c0[d] + 8'd1;
                    chk("win_seg", 32'(seg0), 32'(eseg[d]));
                    chk("win_dp",  32'(dp0),  32'(edp[d]));
                end
            if (en1 != 0) c1++;
        end
    endtask

    task automatic restart_check(input string tag);
        @(negedge clk); chk({tag, "_c1_en"}, 32'(en0), 32'd0);
        @(negedge clk); chk({tag, "_c2_en"}, 32'(en0), 32'd0);
        @(negedge clk); chk({tag, "_c3_en"}, 32'(en0), 32'b0001);
        chk({tag, "_c3_seg"}, 32'(seg0), 32'h3F);
    endtask

    logic [3:0][7:0] c0;
    int              c1;

    initial begin
        bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_data = '0; bus.wr_dp = 1'b0;
        bus.brightness = 4'hF;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_en",  32'(en0),  32'd0);
        chk("rst_seg", 32'(seg0), 32'd0);
        chk("rst_dp",  32'(dp0),  32'd0);
        chk("rst_fd",  32'(fd0),  32'd0);
        reset = 1'b0;
        restart_check("t1");

        // Writes mid-frame stay invisible until commit.
        for (int i = 0; i < N; i++) begin
            bus.wr_en = 1'b1; bus.wr_idx = 3'(i); bus.wr_data = 4'(i + 1); bus.wr_dp = 1'b0;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        wait_fd(1'b1);
        window(32, {7'h66, 7'h4F, 7'h5B, 7'h06}, 4'b0000, c0, c1);
        for (int d = 0; d < N; d++) chk("t2_lit_cnt", 32'(c0[d]), 32'd6);

        // Write landing on the commit cycle itself.
        repeat (31) @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_idx = 3'd3; bus.wr_data = 4'd7;
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk("t3_fd", 32'(fd0), 32'd1);
        window(32, {7'h07, 7'h4F, 7'h5B, 7'h06}, 4'b0000, c0, c1);
        chk("t3_d3_cnt", 32'(c0[3]), 32'd6);

        // Brightness sweep.
        bus.brightness = 4'd0;
        window(40, '0, '0, c0, c1);
        chk("t4_b0_i0", 32'(c0[0] + c0[1] + c0[2] + c0[3]), 32'd0);
        chk("t4_b0_i1", 32'(c1), 32'd0);
        bus.brightness = 4'd4;
        window(136, {7'h07, 7'h4F, 7'h5B, 7'h06}, 4'b0000, c0, c1);
        chk("t4_b4_i1", 32'(c1), 32'd32);
        window(32, {7'h07, 7'h4F, 7'h5B, 7'h06}, 4'b0000, c0, c1);
        chk("t4_b4_i0", 32'(c0[0] + c0[1] + c0[2] + c0[3]), 32'd16);
        bus.brightness = 4'hF;
        window(136, {7'h07, 7'h4F, 7'h5B, 7'h06}, 4'b0000, c0, c1);
        chk("t4_b15_i1", 32'(c1), 32'd128);
        window(32, {7'h07, 7'h4F, 7'h5B, 7'h06}, 4'b0000, c0, c1);
        chk("t4_b15_i0", 32'(c0[0] + c0[1] + c0[2] + c0[3]), 32'd24);

        // Non-BCD value with dp, then an out-of-range index that must be dropped.
        bus.wr_en = 1'b1; bus.wr_idx = 3'd1; bus.wr_data = 4'd12; bus.wr_dp = 1'b1;
        @(negedge clk);
        bus.wr_idx = 3'd5; bus.wr_data = 4'd8; bus.wr_dp = 1'b0;
        @(negedge clk);
        bus.wr_en = 1'b0;
        wait_fd(1'b0);
        window(32, {7'h07, 7'h4F, 7'h00, 7'h06}, 4'b0010, c0, c1);
        chk("t5_d1_cnt", 32'(c0[1]), 32'd6);

        // Reset in the ON phase of digit 2 (frame_done currently visible, t%32==0).
        repeat (19) @(negedge clk);
        chk("t6_pre_en", 32'(en0), 32'b0100);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_en",  32'(en0),  32'd0);
        chk("t6_seg", 32'(seg0), 32'd0);
        chk("t6_dp",  32'(dp0),  32'd0);
        chk("t6_fd",  32'(fd0),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        restart_check("t6");
        wait_fd(1'b0);
        window(32, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, c0, c1);
        for (int d = 0; d < N; d++) chk("t6_zero_cnt", 32'(c0[d]), 32'd6);

        // Random writes and brightness, checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            bus.wr_en   = 1'($urandom_range(0, 1));
            bus.wr_idx  = 3'($urandom_range(0, 7));
            bus.wr_data = 4'($urandom_range(0, 15));
            bus.wr_dp   = 1'($urandom_range(0, 1));
            if (i % 45 == 0) bus.brightness = 4'($urandom_range(0, 15));
        end
        bus.wr_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", pass_cnt, tot_cnt);
        $fatal(1);
    end
endmodule
